// File: rtl/kmac_err_report_if.sv
// Shared types and the error-report bus between the error sources/SW side and kmac_err_report.
package kmac_err_report_pkg;
  typedef struct packed {
    logic        valid;
    logic [7:0]  code;
    logic [23:0] info;
  } err_t;

  typedef logic [3:0] mubi4_t;
  localparam mubi4_t MuBi4True  = 4'h6;
  localparam mubi4_t MuBi4False = 4'h9;
endpackage

interface kmac_err_report_if;
  import kmac_err_report_pkg::*;

  err_t        errchk_err_i;
  err_t        app_err_i;
  err_t        core_err_i;
  logic        fatal_i;
  logic        sw_err_processed_i;
  logic [31:0] err_code_o;
  logic        err_pending_o;
  logic        intr_err_o;
  logic        err_processed_o;
  mubi4_t      clear_after_error_o;
  logic [7:0]  miss_cnt_o;
  logic        fatal_alert_o;

  modport master (
    output errchk_err_i, app_err_i, core_err_i, fatal_i, sw_err_processed_i,
    input  err_code_o, err_pending_o, intr_err_o, err_processed_o,
           clear_after_error_o, miss_cnt_o, fatal_alert_o
  );

  modport slave (
    input  errchk_err_i, app_err_i, core_err_i, fatal_i, sw_err_processed_i,
    output err_code_o, err_pending_o, intr_err_o, err_processed_o,
           clear_after_error_o, miss_cnt_o, fatal_alert_o
  );
endinterface

// File: rtl/kmac_err_report.sv
// Captures the highest-priority error, holds it for SW, drives a timed datapath clear on
// acknowledge, counts dropped errors and latches a terminal fatal alert.
module kmac_err_report
  import kmac_err_report_pkg::*;
#(
    parameter int unsigned ClearCycles = 4
) (
    input logic              clk_i,
    input logic              rst_i,
    kmac_err_report_if.slave bus
);

    // Sparse encoding, pairwise Hamming distance >= 3.
    typedef enum logic [4:0] {
        StIdle  = 5'b01101,
        StHold  = 5'b10110,
        StClear = 5'b00011,
        StFatal = 5'b11000
    } state_e;

    localparam logic [3:0] ClrInit = 4'(ClearCycles - 1);

    state_e      state_q;
    logic [3:0]  clr_cnt_q;
    logic [31:0] err_code_q;
    logic        err_pending_q;
    logic        intr_err_q;
    logic        err_processed_q;
    mubi4_t      clear_q;
    logic [7:0]  miss_cnt_q;
    logic        fatal_alert_q;

    logic [1:0]  n_valid;
    logic        any_valid;
    logic [31:0] sel_code;
    logic [8:0]  miss_sum;
    logic [7:0]  miss_sat;

    always_comb begin
        n_valid   = 2'(bus.errchk_err_i.valid) + 2'(bus.app_err_i.valid) + 2'(bus.core_err_i.valid);
        any_valid = (n_valid != 2'd0);
        sel_code  = '0;
        if (bus.errchk_err_i.valid)   sel_code = {bus.errchk_err_i.code, bus.errchk_err_i.info};
        else if (bus.app_err_i.valid) sel_code = {bus.app_err_i.code, bus.app_err_i.info};
        else if (bus.core_err_i.valid) sel_code = {bus.core_err_i.code, bus.core_err_i.info};
        miss_sum  = {1'b0, miss_cnt_q} + 9'(n_valid);
        miss_sat  = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            clr_cnt_q       <= '0;
            err_code_q      <= '0;
            err_pending_q   <= 1'b0;
            intr_err_q      <= 1'b0;
            err_processed_q <= 1'b0;
            clear_q         <= MuBi4False;
            miss_cnt_q      <= '0;
            fatal_alert_q   <= 1'b0;
        end else if (bus.fatal_i) begin
            // Fatal wins over capture and acknowledge; code and miss count freeze as they are.
            state_q         <= StFatal;
            fatal_alert_q   <= 1'b1;
            clear_q         <= MuBi4False;
            intr_err_q      <= 1'b0;
            err_processed_q <= 1'b0;
        end else begin
            intr_err_q      <= 1'b0;
            err_processed_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        state_q       <= StHold;
                        err_code_q    <= sel_code;
                        err_pending_q <= 1'b1;
                        intr_err_q    <= 1'b1;
                        miss_cnt_q    <= 8'(n_valid - 2'd1);
                    end
                end
                StHold: begin
                    miss_cnt_q <= miss_sat;
                    if (bus.sw_err_processed_i) begin
                        state_q         <= StClear;
                        err_processed_q <= 1'b1;
                        clear_q         <= MuBi4True;
                        clr_cnt_q       <= ClrInit;
                    end
                end
                StClear: begin
                    miss_cnt_q <= miss_sat;
                    if (clr_cnt_q == 4'd0) begin
                        state_q       <= StIdle;
                        err_pending_q <= 1'b0;
                        clear_q       <= MuBi4False;
                    end else begin
                        clr_cnt_q <= clr_cnt_q - 4'd1;
                    end
                end
                StFatal: begin
                    fatal_alert_q <= 1'b1;
                    clear_q       <= MuBi4False;
                end
                default: begin
                    state_q       <= StFatal;
                    fatal_alert_q <= 1'b1;
                    clear_q       <= MuBi4False;
                end
            endcase
        end
    end

    assign bus.err_code_o          = err_code_q;
    assign bus.err_pending_o       = err_pending_q;
    assign bus.intr_err_o          = intr_err_q;
    assign bus.err_processed_o     = err_processed_q;
    assign bus.clear_after_error_o = clear_q;
    assign bus.miss_cnt_o          = miss_cnt_q;
    assign bus.fatal_alert_o       = fatal_alert_q;

endmodule

// File: tb/tb_kmac_err_report.sv
// Directed bench for kmac_err_report: capture, priority, acknowledge/clear, saturation,
// fatal handling and reset behaviour, checked with immediate assertions.
module tb_kmac_err_report;
    import kmac_err_report_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    kmac_err_report_if bus ();

    kmac_err_report #(.ClearCycles(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic no_err();
        bus.errchk_err_i = '0;
        bus.app_err_i    = '0;
        bus.core_err_i   = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".code"},    bus.err_code_o, 32'h0);
        check({tag, ".pending"}, 32'(bus.err_pending_o), 32'h0);
        check({tag, ".intr"},    32'(bus.intr_err_o), 32'h0);
        check({tag, ".proc"},    32'(bus.err_processed_o), 32'h0);
        check({tag, ".clear"},   32'(bus.clear_after_error_o), 32'h9);
        check({tag, ".miss"},    32'(bus.miss_cnt_o), 32'h0);
        check({tag, ".alert"},   32'(bus.fatal_alert_o), 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        no_err();
        bus.fatal_i = 1'b0;
        bus.sw_err_processed_i = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");

        // Single errchk error on the first edge after reset release.
        rst = 1'b0;
        bus.errchk_err_i = {1'b1, 8'h02, 24'h000203};
        tick();
        check("single.code",    bus.err_code_o, 32'h0200_0203);
        check("single.pending", 32'(bus.err_pending_o), 32'h1);
        check("single.intr",    32'(bus.intr_err_o), 32'h1);
        check("single.miss",    32'(bus.miss_cnt_o), 32'h0);
        no_err();
        tick();
        check("single.intr_off", 32'(bus.intr_err_o), 32'h0);
        check("single.hold",     32'(bus.err_pending_o), 32'h1);

        // Acknowledge: one processed pulse, clear asserted for exactly 4 cycles.
        bus.sw_err_processed_i = 1'b1;
        tick();
        bus.sw_err_processed_i = 1'b0;
        check("ack.proc",   32'(bus.err_processed_o), 32'h1);
        check("ack.clear1", 32'(bus.clear_after_error_o), 32'h6);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("ack.clear%0d", i), 32'(bus.clear_after_error_o), 32'h6);
            check($sformatf("ack.proc_off%0d", i), 32'(bus.err_processed_o), 32'h0);
        end
        // First Idle cycle: app + core together, app wins, one miss.
        bus.app_err_i  = {1'b1, 8'h01, 24'h000011};
        bus.core_err_i = {1'b1, 8'h04, 24'h000044};
        tick();
        check("ack.clear_off", 32'(bus.clear_after_error_o), 32'h9);
        check("ack.pending",   32'(bus.err_pending_o), 32'h0);
        check("ack.code_held", bus.err_code_o, 32'h0200_0203);
        tick();
        no_err();
        check("simul.code",    bus.err_code_o, 32'h0100_0011);
        check("simul.miss",    32'(bus.miss_cnt_o), 32'h1);
        check("simul.intr",    32'(bus.intr_err_o), 32'h1);
        check("simul.pending", 32'(bus.err_pending_o), 32'h1);

        // Saturation: errchk valid throughout Hold, count climbs by one per cycle.
        bus.errchk_err_i = {1'b1, 8'h55, 24'h123456};
        for (int i = 0; i < 10; i++) tick();
        check("sat.mid",  32'(bus.miss_cnt_o), 32'd11);
        for (int i = 10; i < 300; i++) tick();
        check("sat.miss", 32'(bus.miss_cnt_o), 32'd255);
        check("sat.code", bus.err_code_o, 32'h0100_0011);
        check("sat.intr", 32'(bus.intr_err_o), 32'h0);
        no_err();

        // Reset on the 2nd Clear cycle takes effect without a clock edge.
        bus.sw_err_processed_i = 1'b1;
        tick();
        bus.sw_err_processed_i = 1'b0;
        check("rclr.clear1", 32'(bus.clear_after_error_o), 32'h6);
        tick();
        check("rclr.clear2", 32'(bus.clear_after_error_o), 32'h6);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("rclr");
        tick();
        rst = 1'b0;
        // SW acknowledge in Idle is ignored.
        bus.sw_err_processed_i = 1'b1;
        tick();
        bus.sw_err_processed_i = 1'b0;
        check("idle_ack.proc",    32'(bus.err_processed_o), 32'h0);
        check("idle_ack.pending", 32'(bus.err_pending_o), 32'h0);
        check("idle_ack.clear",   32'(bus.clear_after_error_o), 32'h9);
        bus.app_err_i = {1'b1, 8'h0A, 24'h000001};
        tick();
        no_err();
        check("post_rst.code", bus.err_code_o, 32'h0A00_0001);
        check("post_rst.intr", 32'(bus.intr_err_o), 32'h1);
        check("post_rst.miss", 32'(bus.miss_cnt_o), 32'h0);

        // Fatal during Clear: alert next cycle, clear dropped, everything frozen.
        bus.sw_err_processed_i = 1'b1;
        tick();
        bus.sw_err_processed_i = 1'b0;
        check("fat.in_clear", 32'(bus.clear_after_error_o), 32'h6);
        bus.fatal_i = 1'b1;
        bus.errchk_err_i = {1'b1, 8'h33, 24'h000033};
        tick();
        bus.fatal_i = 1'b0;
        check("fat.alert", 32'(bus.fatal_alert_o), 32'h1);
        check("fat.clear", 32'(bus.clear_after_error_o), 32'h9);
        check("fat.proc",  32'(bus.err_processed_o), 32'h0);
        bus.app_err_i  = {1'b1, 8'h44, 24'h000044};
        bus.core_err_i = {1'b1, 8'h66, 24'h000066};
        bus.sw_err_processed_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        bus.sw_err_processed_i = 1'b0;
        no_err();
        tick();
        check("fat.stay_alert", 32'(bus.fatal_alert_o), 32'h1);
        check("fat.code",       bus.err_code_o, 32'h0A00_0001);
        check("fat.miss",       32'(bus.miss_cnt_o), 32'h0);
        check("fat.intr",       32'(bus.intr_err_o), 32'h0);
        check("fat.proc2",      32'(bus.err_processed_o), 32'h0);
        check("fat.clear2",     32'(bus.clear_after_error_o), 32'h9);

        // Fatal and error together in Idle: no capture.
        rst = 1'b1;
        tick();
        check("fat_rst.alert", 32'(bus.fatal_alert_o), 32'h0);
        rst = 1'b0;
        bus.fatal_i = 1'b1;
        bus.errchk_err_i = {1'b1, 8'h77, 24'h000077};
        tick();
        bus.fatal_i = 1'b0;
        no_err();
        check("fat_idle.alert",   32'(bus.fatal_alert_o), 32'h1);
        check("fat_idle.code",    bus.err_code_o, 32'h0);
        check("fat_idle.pending", 32'(bus.err_pending_o), 32'h0);
        check("fat_idle.intr",    32'(bus.intr_err_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/kmac_err_report.md
KMAC_ERR_REPORT -- requirements
Module: kmac_err_report

Interface
REQ-001 The block SHALL have parameter ClearCycles, default 4, meaning the number of cycles clear_after_error_o is held MuBi4True (legal range 1..15).
REQ-002 The block SHALL have the port clk_i, input, 1 bit, the single clock.
REQ-003 The block SHALL have the port rst_i, input, 1 bit, the reset, asynchronous and active-high.
REQ-004 The block SHALL have the port errchk_err_i, input, err_t (valid 1, code 8, info 24), the error from the command/config checker.
REQ-005 The block SHALL have the port app_err_i, input, err_t, the error from the application interface.
REQ-006 The block SHALL have the port core_err_i, input, err_t, the error from the KMAC core.
REQ-007 The block SHALL have the port fatal_i, input, 1 bit, the sparse-FSM or escalation fault from neighbouring blocks.
REQ-008 The block SHALL have the port sw_err_processed_i, input, 1 bit, the SW write-1 pulse acknowledging the error.
REQ-009 The block SHALL have the port err_code_o, output, 32 bits, the captured {code, info} (ERR_CODE register).
REQ-010 The block SHALL have the port err_pending_o, output, 1 bit, meaning an error is captured and awaits SW.
REQ-011 The block SHALL have the port intr_err_o, output, 1 bit, a one-cycle interrupt event.
REQ-012 The block SHALL have the port err_processed_o, output, 1 bit, a one-cycle pulse to the checker and core.
REQ-013 The block SHALL have the port clear_after_error_o, output, mubi4_t, the datapath clear request.
REQ-014 The block SHALL have the port miss_cnt_o, output, 8 bits, a saturating count of dropped errors.
REQ-015 The block SHALL have the port fatal_alert_o, output, 1 bit, the level fatal alert.

Function
REQ-016 The FSM SHALL have the states Idle, Hold, Clear and Fatal, using a sparse encoding with minimum Hamming distance 3; any invalid encoding SHALL go to Fatal next cycle.
REQ-017 In Idle, if any source is valid, the block SHALL select by fixed priority errchk > app > core.
REQ-018 On that edge, the block SHALL load err_code_o = {code, info} of the selected source, go to Hold, and set err_pending_o = 1.
REQ-019 intr_err_o SHALL pulse high for exactly one cycle, the first cycle in Hold.
REQ-020 On a capture edge, miss_cnt_o SHALL be reset to the number of non-selected valid sources (0..2).
REQ-021 In Hold or Clear, each cycle miss_cnt_o SHALL increase by the count of valid sources (0..3), saturating at 255; err_code_o SHALL NOT change.
REQ-022 In Hold, sw_err_processed_i = 1 SHALL move the FSM to Clear and pulse err_processed_o for exactly the first Clear cycle.
REQ-023 sw_err_processed_i in Idle, Clear or Fatal SHALL be ignored.
REQ-024 In Clear, clear_after_error_o SHALL be MuBi4True for exactly ClearCycles cycles, counted by a 4-bit down-counter.
REQ-025 After those ClearCycles cycles, the block SHALL return to Idle; err_pending_o SHALL fall on entry to Idle.
REQ-026 In Clear, clear_after_error_o SHALL be MuBi4False in every state other than Clear.
REQ-027 err_code_o SHALL hold its value in Idle until the next capture.
REQ-028 A valid error in the first Idle cycle after Clear SHALL be captured normally (no dead cycle).
REQ-029 fatal_i = 1 in any state SHALL move the FSM to Fatal on the next edge, with precedence over capture and acknowledge.
REQ-030 Fatal SHALL be terminal, exited only by rst_i.
REQ-031 In Fatal, fatal_alert_o SHALL be 1, clear_after_error_o SHALL be MuBi4False, intr_err_o and err_processed_o SHALL be 0, err_code_o SHALL be held, and miss_cnt_o SHALL be frozen.
REQ-032 If fatal_i and a valid error arrive together in Idle, the FSM SHALL go to Fatal and SHALL NOT capture.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst_i asserted at any time, including mid-Clear, SHALL immediately force: FSM Idle, err_code_o 0, err_pending_o 0, intr_err_o 0, err_processed_o 0, clear_after_error_o MuBi4False, miss_cnt_o 0, fatal_alert_o 0, Clear counter 0.
REQ-035 The first capture SHALL be possible on the first clk_i edge after rst_i deasserts.

Verification
REQ-036 Single error: errchk_err_i = {1, 8'h02, 24'h00_0203} for 1 cycle -> err_code_o = 32'h0200_0203, err_pending_o = 1, one intr_err_o pulse, miss_cnt_o = 0.
REQ-037 Simultaneous errors: app (code 8'h01) and core (code 8'h04) valid in the same Idle cycle -> err_code_o[31:24] = 8'h01, miss_cnt_o = 1.
REQ-038 Acknowledge with ClearCycles = 4: sw_err_processed_i pulsed in Hold -> one err_processed_o pulse, MuBi4True for exactly 4 cycles, then Idle with err_pending_o = 0 and err_code_o held.
REQ-039 Saturation: hold errchk_err_i valid for 300 cycles in Hold -> miss_cnt_o = 255, err_code_o unchanged.
REQ-040 Fatal: fatal_i pulsed during Clear -> fatal_alert_o = 1 next cycle, clear_after_error_o = MuBi4False, later sw_err_processed_i and errors ignored until rst_i.
REQ-041 Reset mid-Clear: assert rst_i on the 2nd Clear cycle -> all outputs at reset values the same cycle; error presented 1 cycle after release is captured.
